// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO-fed 8N1 UART transmitter with byte FIFO and toggle handshake
// Software flips commandWord[8] to request a push; the accepted toggle is echoed in statusWord[8].
module mmio_uart_tx #(
   parameter int CLOCKS_PER_BIT = 434,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] commandWord,
   output logic [31:0] statusWord,
   output logic        txd
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLOCKS_PER_BIT);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state, state_n;
   logic [7:0] fifo [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [3:0] count;
   logic ack_toggle;
   logic [7:0] shift, shift_n;
   logic [BW-1:0] baud, baud_n;
   logic [2:0] bit_idx, bit_n;
   logic txd_n, full, empty, push, pop, bit_end;
   logic unused;
   assign unused = ^commandWord[31:9];
   assign full = count == 4'(FIFO_DEPTH);
   assign empty = count == 4'd0;
   assign push = commandWord[8] != ack_toggle && !full;
   assign pop = state == IDLE && !empty;
   assign bit_end = baud == BW'(CLOCKS_PER_BIT - 1);
   assign statusWord = {16'd0, count, state != IDLE || !empty, empty, full, ack_toggle, 8'd0};
   always_comb begin
      state_n = state;
      shift_n = shift;
      bit_n = bit_idx;
      baud_n = (state == IDLE || bit_end) ? '0 : baud + 1'b1;
      case (state)
         IDLE: if (pop) begin
            state_n = START;
            shift_n = fifo[rd_ptr];
         end
         START: if (bit_end) begin
            state_n = DATA;
            bit_n = 3'd0;
         end
         DATA: if (bit_end) begin
            shift_n = shift >> 1;
            bit_n = bit_idx + 3'd1;
            state_n = bit_idx == 3'd7 ? STOP : DATA;
         end
         STOP: if (bit_end) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      // txd is registered, so it is derived from where the FSM is heading
      txd_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         shift <= '0;
         baud <= '0;
         bit_idx <= '0;
         txd <= 1'b1;
         count <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         ack_toggle <= 1'b0;
      end else begin
         state <= state_n;
         shift <= shift_n;
         baud <= baud_n;
         bit_idx <= bit_n;
         txd <= txd_n;
         count <= count + 4'(push) - 4'(pop);
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            ack_toggle <= commandWord[8];
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end
   always_ff @(posedge clock) begin
      if (push) fifo[wr_ptr] <= commandWord[7:0];
   end
endmodule
